demux_sel_arbiter: RTL



---
 rtl/demux_sel_arbiter_pkg.sv | 21 ++
 rtl/demux_sel_arbiter_rr_pick4.sv | 34 +++
 rtl/demux_sel_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/demux_sel_arbiter_pkg.sv
// ============================================================================
// demux_sel_arbiter_pkg : shared constants and types for the demux arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package demux_sel_arbiter_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/demux_sel_arbiter_rr_pick4.sv
// ============================================================================
// rr_pick4 : combinational round-robin picker, first set req from ptr upward
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_pick4
  import demux_sel_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  idx_t              ptr_i,
  output logic              any_o,
  output idx_t              idx_o
);

  idx_t cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    any_o = 1'b0;
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr_i + idx_t'(k);
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_sel_arbiter.sv
// ============================================================================
// demux_sel_arbiter : round-robin 4-channel arbiter driving demux selects,
//                     with a per-grant hold limit and timeout pulse
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module demux_sel_arbiter
  import demux_sel_arbiter_pkg::*;
#(
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned HCW      = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic              grant_valid,
  output logic              sel_i0,
  output logic              sel_i1,
  output logic              timeout
);

  localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);

  state_e         state_q, state_d;
  idx_t           ptr_q, ptr_d;
  idx_t           sel_q, sel_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           gv_q, gv_d;
  logic           timeout_q, timeout_d;

  logic           pick_any;
  idx_t           pick_idx;

  rr_pick4 u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    gv_d      = gv_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          gv_d    = 1'b1;
          hold_d  = HCW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // done on the final allowed cycle counts as a clean release
        if (done || (hold_q == HOLD_LIM)) begin
          gv_d      = 1'b0;
          ptr_d     = sel_q + idx_t'(1);
          hold_d    = '0;
          timeout_d = ~done;
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      hold_q    <= '0;
      gv_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      gv_q      <= gv_d;
      timeout_q <= timeout_d;
    end
  end

  // sel keeps its last value while idle; consumers qualify with grant_valid
  assign grant_valid = gv_q;
  assign sel_i1      = sel_q[1];
  assign sel_i0      = sel_q[0];
  assign timeout     = timeout_q;

endmodule

`default_nettype wire
